// File: rtl/of_pkg.sv
// of_pkg: shared constants for the OpenFlow flow-table responder.
// Contents:
//   KEY_W           total lookup key width (243 bits)
//   *_OFF / *_W     bit offset (LSB) and width of each of the 12 key fields,
//                   packed MSB first as {in_port, eth_src, ..., tp_dst}
//   NPORT_DEF       default forwarding-port bitmap width
//   of_state_e      lookup FSM state encoding
package of_pkg;

    localparam int KEY_W       = 243;
    localparam int NPORT_DEF   = 4;

    localparam int TP_DST_W    = 16;
    localparam int TP_DST_OFF  = 0;
    localparam int TP_SRC_W    = 16;
    localparam int TP_SRC_OFF  = 16;
    localparam int IP_TOS_W    = 8;
    localparam int IP_TOS_OFF  = 32;
    localparam int IP_PROTO_W  = 8;
    localparam int IP_PROTO_OFF = 40;
    localparam int IP_DST_W    = 32;
    localparam int IP_DST_OFF  = 48;
    localparam int IP_SRC_W    = 32;
    localparam int IP_SRC_OFF  = 80;
    localparam int VLAN_PRIO_W = 3;
    localparam int VLAN_PRIO_OFF = 112;
    localparam int VLAN_ID_W   = 12;
    localparam int VLAN_ID_OFF = 115;
    localparam int ETH_TYPE_W  = 16;
    localparam int ETH_TYPE_OFF = 127;
    localparam int ETH_DST_W   = 48;
    localparam int ETH_DST_OFF = 143;
    localparam int ETH_SRC_W   = 48;
    localparam int ETH_SRC_OFF = 191;
    localparam int IN_PORT_W   = 4;
    localparam int IN_PORT_OFF = 239;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RESP   = 2'd2
    } of_state_e;

endpackage

// File: rtl/of_key_match.sv
// of_key_match: combinational masked compare of one flow entry.
// Ports:
//   key    lookup key
//   match  entry match value
//   mask   entry care-mask (1 = compared, 0 = wildcard)
//   valid  entry valid bit
//   hit    1 when the entry is valid and every cared-about bit agrees
module of_key_match #(
    parameter int KEY_W = of_pkg::KEY_W
) (
    input  logic [KEY_W-1:0] key,
    input  logic [KEY_W-1:0] match,
    input  logic [KEY_W-1:0] mask,
    input  logic             valid,
    output logic             hit
);
    import of_pkg::*;

    assign hit = valid & (((key ^ match) & mask) == {KEY_W{1'b0}});

endmodule

// File: rtl/of_flow_table.sv
// of_flow_table: responder end of the forwarder's OpenFlow lookup handshake.
// Scans NENTRY match entries one per cycle in index order; the lowest
// matching index wins, otherwise cfg_miss_port is returned.
// Optional per-entry hit counters are built when FLOW_STATS_EN is defined.
// Ports:
//   sys_clk, sys_rst            clock, synchronous active-high reset
//   of_lookup_req/data          request pulse and key
//   of_lookup_ack/fwd_port      response pulse and forwarding bitmap
//   lookup_busy, lookup_drop    busy flag, pulse for an ignored request
//   tbl_wr_en/addr/valid/match/mask/action   control-plane entry write
//   cfg_miss_port               action on miss
//   stat_addr, stat_count       hit-counter read (one cycle latency)
module of_flow_table #(
    parameter int NPORT  = of_pkg::NPORT_DEF,
    parameter int NENTRY = 16,
    parameter int KEY_W  = of_pkg::KEY_W
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        of_lookup_req,
    input  logic [KEY_W-1:0]            of_lookup_data,
    output logic                        of_lookup_ack,
    output logic [NPORT-1:0]            of_lookup_fwd_port,
    output logic                        lookup_busy,
    input  logic                        tbl_wr_en,
    input  logic [$clog2(NENTRY)-1:0]   tbl_addr,
    input  logic                        tbl_valid,
    input  logic [KEY_W-1:0]            tbl_match,
    input  logic [KEY_W-1:0]            tbl_mask,
    input  logic [NPORT-1:0]            tbl_action,
    input  logic [NPORT-1:0]            cfg_miss_port,
    input  logic [$clog2(NENTRY)-1:0]   stat_addr,
    output logic [31:0]                 stat_count,
    output logic                        lookup_drop
);
    import of_pkg::*;

    localparam int IW = $clog2(NENTRY);
    localparam logic [IW-1:0] LAST_IDX = IW'(NENTRY - 1);

    logic [NENTRY-1:0] valid_r;
    logic [KEY_W-1:0]  match_r  [NENTRY];
    logic [KEY_W-1:0]  mask_r   [NENTRY];
    logic [NPORT-1:0]  action_r [NENTRY];

    of_state_e         state_r, next_state_s;
    logic [IW-1:0]     idx_r;
    logic [KEY_W-1:0]  key_r;
    logic [NPORT-1:0]  fwd_port_r, result_s;
    logic              ack_r, busy_r, drop_r;
    logic              hit_s, last_s, load_s;

    // Entry valid bits; reset empties the table.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            valid_r <= '0;
        end else if (tbl_wr_en) begin
            valid_r[tbl_addr] <= tbl_valid;
        end
    end

    // Entry contents; only meaningful while the matching valid bit is set.
    always_ff @(posedge sys_clk) begin
        if (tbl_wr_en) begin
            match_r[tbl_addr]  <= tbl_match;
            mask_r[tbl_addr]   <= tbl_mask;
            action_r[tbl_addr] <= tbl_action;
        end
    end

    // Registered table reads: a write in the same cycle is seen only next cycle.
    of_key_match #(.KEY_W(KEY_W)) u_key_match (
        .key   (key_r),
        .match (match_r[idx_r]),
        .mask  (mask_r[idx_r]),
        .valid (valid_r[idx_r]),
        .hit   (hit_s)
    );

    assign last_s = (idx_r == LAST_IDX);

    // Next-state and result selection for the lookup scan.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        result_s     = fwd_port_r;
        case (state_r)
            IDLE: begin
                if (of_lookup_req) begin
                    next_state_s = SEARCH;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SEARCH: begin
                if (hit_s) begin
                    next_state_s = RESP;
                    load_s       = 1'b1;
                    result_s     = action_r[idx_r];
                end else if (last_s) begin
                    next_state_s = RESP;
                    load_s       = 1'b1;
                    result_s     = cfg_miss_port;
                end else begin
                    next_state_s = SEARCH;
                end
            end
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // FSM state, scan index, latched key and registered handshake outputs.
    // ack and busy are registered from the next state so they line up with RESP.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r    <= IDLE;
            idx_r      <= '0;
            key_r      <= '0;
            fwd_port_r <= '0;
            ack_r      <= 1'b0;
            busy_r     <= 1'b0;
            drop_r     <= 1'b0;
        end else begin
            state_r <= next_state_s;
            ack_r   <= (next_state_s == RESP);
            busy_r  <= (next_state_s != IDLE);
            drop_r  <= of_lookup_req && (state_r != IDLE);
            if (state_r == IDLE && of_lookup_req) begin
                key_r <= of_lookup_data;
                idx_r <= '0;
            end else if (state_r == SEARCH && !load_s) begin
                idx_r <= idx_r + IW'(1);
            end
            if (load_s) begin
                fwd_port_r <= result_s;
            end
        end
    end

    assign of_lookup_ack      = ack_r;
    assign of_lookup_fwd_port = fwd_port_r;
    assign lookup_busy        = busy_r;
    assign lookup_drop        = drop_r;

`ifdef FLOW_STATS_EN
    logic [31:0] count_r [NENTRY];
    logic [31:0] stat_count_r;

    // Saturating per-entry hit counters; a table write clears and beats a hit.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < NENTRY; i++) begin
                count_r[i] <= 32'd0;
            end
            stat_count_r <= 32'd0;
        end else begin
            for (int i = 0; i < NENTRY; i++) begin
                if (tbl_wr_en && tbl_addr == IW'(i)) begin
                    count_r[i] <= 32'd0;
                end else if (state_r == SEARCH && hit_s && idx_r == IW'(i) &&
                             count_r[i] != 32'hFFFF_FFFF) begin
                    count_r[i] <= count_r[i] + 32'd1;
                end
            end
            stat_count_r <= count_r[stat_addr];
        end
    end

    assign stat_count = stat_count_r;
`else
    logic stat_unused_s;
    assign stat_unused_s = ^stat_addr;
    assign stat_count    = 32'd0;
`endif

endmodule

// File: tb/tb_of_flow_table.sv
module tb_of_flow_table;
    import of_pkg::*;

    localparam int NP = 4;
    localparam int NE = 16;
`ifdef FLOW_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            sys_clk = 1'b0;
    logic            sys_rst = 1'b1;
    logic            of_lookup_req = 1'b0;
    logic [KEY_W-1:0] of_lookup_data = '0;
    logic            of_lookup_ack;
    logic [NP-1:0]   of_lookup_fwd_port;
    logic            lookup_busy;
    logic            tbl_wr_en = 1'b0;
    logic [3:0]      tbl_addr = 4'd0;
    logic            tbl_valid = 1'b0;
    logic [KEY_W-1:0] tbl_match = '0;
    logic [KEY_W-1:0] tbl_mask = '0;
    logic [NP-1:0]   tbl_action = '0;
    logic [NP-1:0]   cfg_miss_port = '0;
    logic [3:0]      stat_addr = 4'd0;
    logic [31:0]     stat_count;
    logic            lookup_drop;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    of_flow_table #(.NPORT(NP), .NENTRY(NE), .KEY_W(KEY_W)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .of_lookup_req(of_lookup_req), .of_lookup_data(of_lookup_data),
        .of_lookup_ack(of_lookup_ack), .of_lookup_fwd_port(of_lookup_fwd_port),
        .lookup_busy(lookup_busy), .tbl_wr_en(tbl_wr_en), .tbl_addr(tbl_addr),
        .tbl_valid(tbl_valid), .tbl_match(tbl_match), .tbl_mask(tbl_mask),
        .tbl_action(tbl_action), .cfg_miss_port(cfg_miss_port),
        .stat_addr(stat_addr), .stat_count(stat_count), .lookup_drop(lookup_drop)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [KEY_W-1:0] mk_key(input logic [47:0] dst, input logic [15:0] et);
        logic [KEY_W-1:0] k;
        k = '0;
        k[ETH_DST_OFF +: ETH_DST_W]   = dst;
        k[ETH_TYPE_OFF +: ETH_TYPE_W] = et;
        k[IP_SRC_OFF +: IP_SRC_W]     = 32'hC0A8_0001;
        k[IN_PORT_OFF +: IN_PORT_W]   = 4'd3;
        return k;
    endfunction

    function automatic logic [KEY_W-1:0] mask_dst();
        logic [KEY_W-1:0] m;
        m = '0;
        m[ETH_DST_OFF +: ETH_DST_W] = {ETH_DST_W{1'b1}};
        return m;
    endfunction

    function automatic logic [KEY_W-1:0] mask_et();
        logic [KEY_W-1:0] m;
        m = '0;
        m[ETH_TYPE_OFF +: ETH_TYPE_W] = {ETH_TYPE_W{1'b1}};
        return m;
    endfunction

    task automatic wr(input logic [3:0] a, input logic v, input logic [KEY_W-1:0] mt,
                      input logic [KEY_W-1:0] mk, input logic [NP-1:0] act);
        tbl_wr_en = 1'b1; tbl_addr = a; tbl_valid = v;
        tbl_match = mt; tbl_mask = mk; tbl_action = act;
        tick();
        tbl_wr_en = 1'b0;
    endtask

    // After return, cyc = 1 means the first cycle after the sampling edge.
    task automatic start_req(input logic [KEY_W-1:0] k);
        of_lookup_req = 1'b1; of_lookup_data = k;
        tick();
        of_lookup_req = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_ack(output int lat, output logic [NP-1:0] port);
        while (of_lookup_ack !== 1'b1 && cyc < 60) tick();
        lat  = (of_lookup_ack === 1'b1) ? cyc : -1;
        port = of_lookup_fwd_port;
    endtask

    task automatic do_lookup(input logic [KEY_W-1:0] k, output int lat, output logic [NP-1:0] port);
        start_req(k);
        wait_ack(lat, port);
        tick();
    endtask

    logic [KEY_W-1:0] key_a, key_b, key_c;
    int lat, acks;
    logic [NP-1:0] port;

    initial begin
        key_a = mk_key(48'hAAAA_0000_0006, 16'h86DD);
        key_b = mk_key(48'hBBBB_0000_0002, 16'h86DD);
        key_c = mk_key(48'hCCCC_0000_0005, 16'h86DD);

        // Reset state
        tick(); tick();
        sys_rst = 1'b0;
        chk("rst_ack", 32'(of_lookup_ack), 32'd0);
        chk("rst_busy", 32'(lookup_busy), 32'd0);
        chk("rst_drop", 32'(lookup_drop), 32'd0);
        chk("rst_fwd", 32'(of_lookup_fwd_port), 32'd0);
        chk("rst_stat", stat_count, 32'd0);

        // Single eth_dst entry at index 0
        wr(4'd0, 1'b1, mk_key(48'h0011_2233_4455, 16'h0000), mask_dst(), 4'b0010);
        start_req(mk_key(48'h0011_2233_4455, 16'h1234));
        chk("busy_after_req", 32'(lookup_busy), 32'd1);
        wait_ack(lat, port);
        chk("hit0_lat", 32'(lat), 32'd2);
        chk("hit0_port", 32'(port), 32'b0010);
        tick();
        chk("ack_one_cycle", 32'(of_lookup_ack), 32'd0);
        chk("fwd_hold", 32'(of_lookup_fwd_port), 32'b0010);
        do_lookup(mk_key(48'h0011_2233_4456, 16'h1234), lat, port);
        chk("nearmiss_lat", 32'(lat), 32'd17);
        chk("nearmiss_port", 32'(port), 32'd0);

        // Lowest index wins among entries 3 and 7
        wr(4'd0, 1'b0, '0, '0, 4'b0000);
        wr(4'd3, 1'b1, mk_key(48'h0, 16'h0800), mask_et(), 4'b0100);
        wr(4'd7, 1'b1, mk_key(48'h0, 16'h0800), mask_et(), 4'b1000);
        do_lookup(mk_key(48'hDEAD_BEEF_0001, 16'h0800), lat, port);
        chk("prio_lat", 32'(lat), 32'd5);
        chk("prio_port", 32'(port), 32'b0100);
        wr(4'd3, 1'b0, '0, '0, 4'b0000);
        do_lookup(mk_key(48'hDEAD_BEEF_0001, 16'h0800), lat, port);
        chk("idx7_lat", 32'(lat), 32'd9);
        chk("idx7_port", 32'(port), 32'b1000);

        // Empty table: miss actions
        wr(4'd7, 1'b0, '0, '0, 4'b0000);
        cfg_miss_port = 4'b1111;
        do_lookup(mk_key(48'hDEAD_BEEF_0001, 16'h0800), lat, port);
        chk("miss_lat", 32'(lat), 32'd17);
        chk("miss_port", 32'(port), 32'b1111);
        cfg_miss_port = 4'b0000;
        do_lookup(mk_key(48'hDEAD_BEEF_0001, 16'h0800), lat, port);
        chk("drop_lat", 32'(lat), 32'd17);
        chk("drop_port", 32'(port), 32'd0);

        // Request while busy is ignored
        wr(4'd2, 1'b1, key_b, mask_dst(), 4'b1100);
        wr(4'd6, 1'b1, key_a, mask_dst(), 4'b0011);
        start_req(key_a);
        tick(); tick();
        of_lookup_req = 1'b1; of_lookup_data = key_b;
        tick();
        of_lookup_req = 1'b0;
        chk("drop_pulse", 32'(lookup_drop), 32'd1);
        tick();
        chk("drop_one_cycle", 32'(lookup_drop), 32'd0);
        wait_ack(lat, port);
        chk("busy_req_lat", 32'(lat), 32'd8);
        chk("busy_req_port", 32'(port), 32'b0011);
        acks = 0;
        repeat (20) begin
            tick();
            if (of_lookup_ack === 1'b1) acks++;
        end
        chk("busy_req_extra_ack", 32'(acks), 32'd0);

        // Write to entry 5 in the cycle it is compared: old contents used
        wr(4'd5, 1'b1, key_c, mask_dst(), 4'b0101);
        start_req(key_c);
        repeat (5) tick();
        tbl_wr_en = 1'b1; tbl_addr = 4'd5; tbl_valid = 1'b0;
        tick();
        tbl_wr_en = 1'b0;
        wait_ack(lat, port);
        chk("wr_same_lat", 32'(lat), 32'd7);
        chk("wr_same_port", 32'(port), 32'b0101);
        tick();
        // Same write two cycles earlier: entry gone before its compare
        wr(4'd5, 1'b1, key_c, mask_dst(), 4'b0101);
        cfg_miss_port = 4'b1001;
        start_req(key_c);
        repeat (3) tick();
        tbl_wr_en = 1'b1; tbl_addr = 4'd5; tbl_valid = 1'b0;
        tick();
        tbl_wr_en = 1'b0;
        wait_ack(lat, port);
        chk("wr_early_lat", 32'(lat), 32'd17);
        chk("wr_early_port", 32'(port), 32'b1001);
        tick();

        // Hit counters on entry 2
        repeat (3) begin
            do_lookup(key_b, lat, port);
            chk("stat_hit_lat", 32'(lat), 32'd4);
        end
        stat_addr = 4'd2;
        tick(); tick();
        chk("stat_count3", stat_count, STATS ? 32'd3 : 32'd0);
        wr(4'd2, 1'b1, key_b, mask_dst(), 4'b1100);
        tick(); tick();
        chk("stat_cleared", stat_count, 32'd0);

        // Reset in the middle of a scan
        start_req(key_a);
        tick(); tick();
        sys_rst = 1'b1;
        tick();
        chk("midrst_busy", 32'(lookup_busy), 32'd0);
        chk("midrst_ack", 32'(of_lookup_ack), 32'd0);
        sys_rst = 1'b0;
        acks = 0;
        repeat (20) begin
            tick();
            if (of_lookup_ack === 1'b1) acks++;
        end
        chk("midrst_no_ack", 32'(acks), 32'd0);
        cfg_miss_port = 4'b0110;
        do_lookup(key_a, lat, port);
        chk("midrst_empty_lat", 32'(lat), 32'd17);
        chk("midrst_empty_port", 32'(port), 32'b0110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/of_flow_table.md
Name: of_flow_table

Overview:
- Responder end of the forwarder's OpenFlow lookup handshake. Holds NENTRY match entries, each with a value, a care-mask and an action.
- On a lookup request it scans the entries in index order; the lowest matching index wins. It returns that entry's forwarding-port bitmap, or the miss action if nothing matches.
- Sits between one forwarder instance and the control-plane table-write path.

Parameters:
- NPORT, 4, width of the forwarding-port bitmap.
- NENTRY, 16, number of flow entries (power of two, 2..256).
- KEY_W, 243, lookup key width: {in_port[3:0], eth_src, eth_dst, eth_type, vlan_id, vlan_prio, ip_src, ip_dst, ip_proto, ip_tos, tp_src, tp_dst}, MSB first.

Ports:
- sys_clk  in  1  single clock.
- sys_rst  in  1  synchronous, active-high reset.
- of_lookup_req  in  1  one-cycle request pulse.
- of_lookup_data  in  KEY_W  lookup key, sampled only in the cycle req is high.
- of_lookup_ack  out  1  one-cycle response pulse.
- of_lookup_fwd_port  out  NPORT  result; valid while ack is high, holds its value afterwards.
- lookup_busy  out  1  high from the cycle after an accepted req up to and including the ack cycle.
- tbl_wr_en  in  1  entry write strobe.
- tbl_addr  in  log2(NENTRY)  entry index to write.
- tbl_valid  in  1  entry valid bit.
- tbl_match  in  KEY_W  match value.
- tbl_mask  in  KEY_W  care-mask; 1 = bit compared, 0 = wildcard.
- tbl_action  in  NPORT  forwarding bitmap for the entry.
- cfg_miss_port  in  NPORT  action on miss (all zeros = drop).
- stat_addr  in  log2(NENTRY)  statistics read index.
- stat_count  out  32  hit count of entry stat_addr, registered, one cycle of latency.
- lookup_drop  out  1  pulse: a req arrived while busy and was ignored.

Behaviour:
- Reset values:
  - All entries become invalid.
  - ack, busy and lookup_drop are 0.
  - fwd_port is 0; stat_count is 0.
  - FSM goes to IDLE, whatever state it was in when reset asserts; an in-flight lookup gets no ack.
- IDLE state: on req=1, latch the key, set idx=0, go to SEARCH.
- SEARCH state, one entry compared per cycle:
  - Entry idx matches when valid[idx] and ((key ^ match[idx]) & mask[idx]) == 0.
  - On a match: result <= action[idx], go to RESP.
  - No match and idx == NENTRY-1: result <= cfg_miss_port as sampled that cycle, go to RESP.
  - Otherwise idx <= idx + 1.
- RESP state: ack=1 for exactly one cycle, fwd_port=result, then IDLE. A req in that RESP cycle is dropped. A req is accepted in IDLE, so back-to-back lookups can start the cycle after ack.
- Latency, with req sampled at edge T:
  - A hit at index k gives ack during cycle T+2+k.
  - A full miss gives ack during cycle T+1+NENTRY.
- A req while busy (SEARCH or RESP) is ignored: the latched key is unchanged and lookup_drop pulses in the next cycle.
- Table writes:
  - Accepted in any state and take effect at the next edge.
  - A SEARCH compare in the same cycle as a write to that entry uses the old contents.
  - An all-zero mask on a valid entry matches every key (wildcard entry).
  - Writing tbl_valid=0 removes the entry.

Optional Feature:
- Macro: FLOW_STATS_EN.
- Defined:
  - Each entry has a 32-bit hit counter, incremented in the cycle the FSM enters RESP on a hit.
  - Counters saturate at 0xFFFFFFFF and do not wrap.
  - A table write to an entry clears its counter; if a hit and a write to the same entry coincide, the clear wins.
  - Misses are not counted.
  - stat_count <= count[stat_addr] each cycle.
- Undefined: no counters; stat_count is constant 0 and the ports remain.

Decomposition:
- Package of_pkg holds:
  - KEY_W and the field offset/width constants for each of the 12 fields.
  - FSM state encoding (IDLE, SEARCH, RESP).
  - Default NPORT.
- Sub-module of_key_match: combinational masked compare of key, match, mask and valid, giving a hit output. It is instantiated once, fed from the entry at idx.

Test Plan:
- Reset, write entry 0 {valid, mask all ones on eth_dst only, match eth_dst=00:11:22:33:44:55, action 4'b0010}, req with that eth_dst -> ack at T+2, fwd_port 4'b0010.
- Entries 3 and 7 both match, actions 4'b0100 and 4'b1000 -> ack at T+5 with 4'b0100 (lowest index wins).
- No valid entries, cfg_miss_port=4'b1111, NENTRY=16 -> ack at T+17 with 4'b1111. Repeat with cfg_miss_port=0 -> fwd_port 0 (drop).
- Second req 3 cycles after the first -> ignored, lookup_drop pulses, exactly one ack, result from the first key.
- Write entry 5 invalid while SEARCH is at idx=5 -> that compare still hits the old entry. Repeat with the write 2 cycles earlier -> miss.
- sys_rst asserted mid-SEARCH -> no ack ever, busy=0 next cycle, all entries invalid. With FLOW_STATS_EN: 3 hits on entry 2 -> stat_count=3; rewrite entry 2 -> 0.
